// File: rtl/bus_pkg.sv
// Shared bus package: default bus widths, slave region map and the DMA
// master state encoding. Imported by dma_addr_gen and bus_dma_master.
package bus_pkg;
  localparam int BUS_ADDR_W = 8;
  localparam int BUS_DATA_W = 32;
  localparam int DMA_LEN_W  = 8;

  // Slave address regions on the 2-master/2-slave bus
  localparam logic [7:0] S0_BASE   = 8'h00;
  localparam logic [7:0] S1_BASE   = 8'h20;
  localparam logic [7:0] REGION_SZ = 8'h20;

  typedef enum logic [2:0] {IDLE, REQ, RD, CAP, WR, FIN} dma_state_t;
endpackage

// File: rtl/dma_addr_gen.sv
// Address/length counters for the DMA master.
//   clk, reset        : clock, synchronous active-high reset
//   load_i            : load src/dst/len (accepted start)
//   inc_i             : one word written: bump src/dst, decrement remaining
//   src_i/dst_i/len_i : start configuration
//   src_o/dst_o       : current source / destination word address
//   rem_o             : words still to copy
//   last_o            : remaining count reaches zero on the next increment
module dma_addr_gen
  import bus_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int LEN_W  = DMA_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              inc_i,
  input  logic [ADDR_W-1:0] src_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic [ADDR_W-1:0] src_o,
  output logic [ADDR_W-1:0] dst_o,
  output logic [LEN_W-1:0]  rem_o,
  output logic              last_o
);
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [LEN_W-1:0]  rem_q;

  // Address counters wrap naturally at 2**ADDR_W
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q <= '0;
      dst_q <= '0;
      rem_q <= '0;
    end else if (load_i) begin
      src_q <= src_i;
      dst_q <= dst_i;
      rem_q <= len_i;
    end else if (inc_i) begin
      src_q <= src_q + 1'b1;
      dst_q <= dst_q + 1'b1;
      rem_q <= rem_q - 1'b1;
    end
  end

  assign src_o  = src_q;
  assign dst_o  = dst_q;
  assign rem_o  = rem_q;
  assign last_o = (rem_q == LEN_W'(1));
endmodule

// File: rtl/bus_dma_master.sv
// Bus DMA master: copies len words from src_addr.. to dst_addr.. over one
// master port of the shared bus, holding the bus for the whole transfer.
// Optional feature macro DMA_FILL_EN adds fill/fill_data: a fill transfer
// writes fill_data to every destination word, one cycle per word, no reads.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   start, src_addr,
//   dst_addr, len         : start pulse and transfer configuration
//   busy, done            : transfer in progress / 1-cycle completion pulse
//   m_req, m_grant        : bus request / arbiter grant
//   m_address, m_wr,
//   m_dout, m_din         : bus address, write strobe, write data, read data
//   fill, fill_data       : (DMA_FILL_EN only) fill mode and pattern
module bus_dma_master
  import bus_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W,
  parameter int LEN_W  = DMA_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              m_req,
  input  logic              m_grant,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_wr,
  output logic [DATA_W-1:0] m_dout,
  input  logic [DATA_W-1:0] m_din
`ifdef DMA_FILL_EN
  ,
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_data
`endif
);
  dma_state_t        state_q, state_d;
  logic [DATA_W-1:0] buf_q;
  logic [ADDR_W-1:0] addr_hold_q;
  logic [DATA_W-1:0] dout_hold_q;
  logic [ADDR_W-1:0] src_cnt, dst_cnt;
  logic [LEN_W-1:0]  rem;
  logic              last;
  logic              load, inc;
  logic              fill_mode;
  logic [DATA_W-1:0] wr_data;

  // Only an idle master accepts start; start while busy is dropped
  assign load = (state_q == IDLE) && start;
  assign inc  = (state_q == WR) && m_grant;

  dma_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_addr (
    .clk    (clk),
    .reset  (reset),
    .load_i (load),
    .inc_i  (inc),
    .src_i  (src_addr),
    .dst_i  (dst_addr),
    .len_i  (len),
    .src_o  (src_cnt),
    .dst_o  (dst_cnt),
    .rem_o  (rem),
    .last_o (last)
  );

`ifdef DMA_FILL_EN
  logic              fill_q;
  logic [DATA_W-1:0] fill_data_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_q      <= 1'b0;
      fill_data_q <= '0;
    end else if (load) begin
      fill_q      <= fill;
      fill_data_q <= fill_data;
    end
  end
  assign fill_mode = fill_q;
  assign wr_data   = fill_q ? fill_data_q : buf_q;
`else
  assign fill_mode = 1'b0;
  assign wr_data   = buf_q;
`endif

  // State register, read buffer and last-driven bus values
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      addr_hold_q <= '0;
      dout_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_hold_q <= m_address;
      dout_hold_q <= m_dout;
      if (state_q == CAP && m_grant) buf_q <= m_din;
    end
  end

  // Next state. Losing grant freezes RD/WR; losing it in CAP discards the
  // in-flight read and goes back to RD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start)   state_d = (len == '0) ? FIN : REQ;
      REQ:  if (m_grant) state_d = fill_mode ? WR : RD;
      RD:   if (m_grant) state_d = CAP;
      CAP:  state_d = m_grant ? WR : RD;
      WR:   if (m_grant) state_d = last ? FIN : (fill_mode ? WR : RD);
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == FIN);
    m_req     = (state_q == REQ) || (state_q == RD) ||
                (state_q == CAP) || (state_q == WR);
    m_wr      = (state_q == WR) && m_grant;
    m_address = addr_hold_q;
    m_dout    = dout_hold_q;
    case (state_q)
      RD, CAP: m_address = src_cnt;
      WR: begin
        m_address = dst_cnt;
        m_dout    = wr_data;
      end
      default: ;
    endcase
  end

  // rem is kept for debug visibility; the FSM only needs the last flag
  logic unused_rem;
  assign unused_rem = ^rem;
endmodule
